box_renderer: RTL and testbench

Pixel generator sitting directly downstream of the VGA timing controller. Consumes `hPixel`, `vLine`, `vActive`, `hSync` and `vSync`, and draws a solid box on a flat background. The box bounces around the visible area, moving once per frame. Produces registered 12-bit RGB plus sync signals delayed to stay aligned with the colour data.

---
 rtl/box_renderer_if.sv | 25 ++
 rtl/box_renderer.sv | 148 ++++++++++++++
 tb/tb_box_renderer.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/box_renderer_if.sv
// Pixel-stream bundle between the VGA timing controller, the box renderer and its consumer.
// The master drives timing and sees colour; the slave (renderer) does the reverse.
interface box_renderer_if;
    logic       vActive;
    logic       hSync;
    logic       vSync;
    logic [9:0] hPixel;
    logic [9:0] vLine;
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
    logic       hSyncOut;
    logic       vSyncOut;
    logic       frameTick;

    modport master (
        output vActive, hSync, vSync, hPixel, vLine,
        input  red, green, blue, hSyncOut, vSyncOut, frameTick
    );

    modport slave (
        input  vActive, hSync, vSync, hPixel, vLine,
        output red, green, blue, hSyncOut, vSyncOut, frameTick
    );
endinterface

// File: rtl/box_renderer.sv
// Bouncing-box pixel generator: RGB444 and syncs registered with 1-clock latency; free-running, no backpressure.
// Macro BOX_BORDER_EN draws a white one-pixel perimeter around the box.
module box_renderer #(
    parameter int          H_RES     = 640,
    parameter int          V_RES     = 480,
    parameter int          BOX_SIZE  = 32,
    parameter int          STEP      = 2,
    parameter logic [11:0] BG_COLOR  = 12'h00F,
    parameter logic [11:0] BOX_COLOR = 12'hFF0
) (
    input  logic          clock,
    input  logic          rst,
    box_renderer_if.slave vga
);
    localparam logic [10:0] HRES_W = 11'(H_RES);
    localparam logic [10:0] VRES_W = 11'(V_RES);
    localparam logic [10:0] SIZE_W = 11'(BOX_SIZE);
    localparam logic [10:0] STEP_W = 11'(STEP);

    typedef enum logic [1:0] {DRAW, MOVE_X, MOVE_Y} state_t;

    state_t      state_q, state_d;
    logic [9:0]  boxX_q, boxX_d;
    logic [9:0]  boxY_q, boxY_d;
    logic        dirX_q, dirX_d;
    logic        dirY_q, dirY_d;
    logic [11:0] rgb_q, rgb_d;
    logic        hSync_q, vSync_q;
    logic        frameTick_q, frameTick_d;

    logic        update_evt;
    logic [10:0] x_ext, y_ext, h_ext, v_ext;
    logic        in_x, in_y;

    // Arithmetic runs 11 bits wide so box edge plus step never wraps.
    assign x_ext = {1'b0, boxX_q};
    assign y_ext = {1'b0, boxY_q};
    assign h_ext = {1'b0, vga.hPixel};
    assign v_ext = {1'b0, vga.vLine};

    assign update_evt = (vga.hPixel == 10'd0) && (v_ext == VRES_W);

    always_comb begin
        state_d     = state_q;
        boxX_d      = boxX_q;
        boxY_d      = boxY_q;
        dirX_d      = dirX_q;
        dirY_d      = dirY_q;
        frameTick_d = 1'b0;
        case (state_q)
            DRAW: begin
                if (update_evt) begin
                    state_d = MOVE_X;
                end
            end
            MOVE_X: begin
                state_d = MOVE_Y;
                if (dirX_q && (x_ext + SIZE_W + STEP_W > HRES_W)) begin
                    boxX_d = 10'(HRES_W - SIZE_W);
                    dirX_d = 1'b0;
                end else if (!dirX_q && (x_ext < STEP_W)) begin
                    boxX_d = 10'd0;
                    dirX_d = 1'b1;
                end else if (dirX_q) begin
                    boxX_d = 10'(x_ext + STEP_W);
                end else begin
                    boxX_d = 10'(x_ext - STEP_W);
                end
            end
            MOVE_Y: begin
                state_d     = DRAW;
                frameTick_d = 1'b1;
                if (dirY_q && (y_ext + SIZE_W + STEP_W > VRES_W)) begin
                    boxY_d = 10'(VRES_W - SIZE_W);
                    dirY_d = 1'b0;
                end else if (!dirY_q && (y_ext < STEP_W)) begin
                    boxY_d = 10'd0;
                    dirY_d = 1'b1;
                end else if (dirY_q) begin
                    boxY_d = 10'(y_ext + STEP_W);
                end else begin
                    boxY_d = 10'(y_ext - STEP_W);
                end
            end
            default: begin
                state_d = DRAW;
            end
        endcase
    end

    assign in_x = (h_ext >= x_ext) && (h_ext < x_ext + SIZE_W);
    assign in_y = (v_ext >= y_ext) && (v_ext < y_ext + SIZE_W);

`ifdef BOX_BORDER_EN
    logic on_edge;
    assign on_edge = (h_ext == x_ext) || (h_ext == x_ext + SIZE_W - 11'd1) ||
                     (v_ext == y_ext) || (v_ext == y_ext + SIZE_W - 11'd1);

    always_comb begin
        rgb_d = BG_COLOR;
        if (!vga.vActive) begin
            rgb_d = 12'h000;
        end else if (in_x && in_y) begin
            rgb_d = on_edge ? 12'hFFF : BOX_COLOR;
        end
    end
`else
    always_comb begin
        rgb_d = BG_COLOR;
        if (!vga.vActive) begin
            rgb_d = 12'h000;
        end else if (in_x && in_y) begin
            rgb_d = BOX_COLOR;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q     <= DRAW;
            boxX_q      <= 10'd0;
            boxY_q      <= 10'd0;
            dirX_q      <= 1'b1;
            dirY_q      <= 1'b1;
            rgb_q       <= 12'h000;
            hSync_q     <= 1'b1;
            vSync_q     <= 1'b0;
            frameTick_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            boxX_q      <= boxX_d;
            boxY_q      <= boxY_d;
            dirX_q      <= dirX_d;
            dirY_q      <= dirY_d;
            rgb_q       <= rgb_d;
            hSync_q     <= vga.hSync;
            vSync_q     <= vga.vSync;
            frameTick_q <= frameTick_d;
        end
    end

    assign vga.red       = rgb_q[11:8];
    assign vga.green     = rgb_q[7:4];
    assign vga.blue      = rgb_q[3:0];
    assign vga.hSyncOut  = hSync_q;
    assign vga.vSyncOut  = vSync_q;
    assign vga.frameTick = frameTick_q;
endmodule

// File: tb/tb_box_renderer.sv
// Bench for box_renderer: reference position model feeds a per-cycle expected-output queue.
// Build with BOX_BORDER_EN defined to exercise the perimeter colour.
module tb_box_renderer;
    localparam int          H_RES = 640;
    localparam int          V_RES = 480;
    localparam int          BOX   = 32;
    localparam int          STEP  = 2;
    localparam logic [11:0] BG_C  = 12'h00F;
    localparam logic [11:0] BOX_C = 12'hFF0;

    typedef struct packed {
        logic [11:0] rgb;
        logic        hso;
        logic        vso;
        logic        tick;
    } exp_t;

    logic clock = 1'b0;
    logic rst   = 1'b1;

    box_renderer_if vif ();

    box_renderer dut (
        .clock (clock),
        .rst   (rst),
        .vga   (vif)
    );

    always #5 clock = ~clock;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    int   m_x, m_y;
    bit   m_dx, m_dy;
    int   m_phase;

    function automatic logic [11:0] model_color(input int h, input int v, input bit act);
        if (!act) return 12'h000;
        if (h >= m_x && h < m_x + BOX && v >= m_y && v < m_y + BOX) begin
`ifdef BOX_BORDER_EN
            if (h == m_x || h == m_x + BOX - 1 || v == m_y || v == m_y + BOX - 1) return 12'hFFF;
`endif
            return BOX_C;
        end
        return BG_C;
    endfunction

    task automatic model_reset();
        m_x = 0; m_y = 0; m_dx = 1'b1; m_dy = 1'b1; m_phase = 0;
    endtask

    task automatic model_advance(input bit evt);
        case (m_phase)
            0: if (evt) m_phase = 1;
            1: begin
                if (m_dx && m_x + BOX + STEP > H_RES) begin m_x = H_RES - BOX; m_dx = 1'b0; end
                else if (!m_dx && m_x < STEP) begin m_x = 0; m_dx = 1'b1; end
                else m_x = m_dx ? m_x + STEP : m_x - STEP;
                m_phase = 2;
            end
            default: begin
                if (m_dy && m_y + BOX + STEP > V_RES) begin m_y = V_RES - BOX; m_dy = 1'b0; end
                else if (!m_dy && m_y < STEP) begin m_y = 0; m_dy = 1'b1; end
                else m_y = m_dy ? m_y + STEP : m_y - STEP;
                m_phase = 0;
            end
        endcase
    endtask

    // One pixel clock: drive inputs, queue the expected registered outputs, advance the model.
    task automatic step(input int h, input int v, input bit act, input bit hs, input bit vs, input bit r);
        exp_t e;
        vif.hPixel  = 10'(h);
        vif.vLine   = 10'(v);
        vif.vActive = act;
        vif.hSync   = hs;
        vif.vSync   = vs;
        rst         = r;
        if (r) begin
            e = '{rgb: 12'h000, hso: 1'b1, vso: 1'b0, tick: 1'b0};
            sb.push_back(e);
            model_reset();
        end else begin
            e = '{rgb: model_color(h, v, act), hso: hs, vso: vs, tick: (m_phase == 2)};
            sb.push_back(e);
            model_advance(h == 0 && v == V_RES);
        end
        @(posedge clock);
        #2;
    endtask

    task automatic probe();
        int h, v;
        h = m_x + int'($urandom_range(0, 37)) - 3;
        v = m_y + int'($urandom_range(0, 37)) - 3;
        if (h < 0) h = 0;
        if (h > H_RES - 1) h = H_RES - 1;
        if (v < 0) v = 0;
        if (v > V_RES - 1) v = V_RES - 1;
        step(h, v, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic frame_update();
        step(0, V_RES, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        repeat (3) probe();
    endtask

    // Scoreboard: one expected entry is retired per clock.
    initial begin
        exp_t e, got;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() != 0) begin
                e   = sb.pop_front();
                got = '{rgb: {vif.red, vif.green, vif.blue}, hso: vif.hSyncOut,
                        vso: vif.vSyncOut, tick: vif.frameTick};
                vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL pixel_out rgb/hso/vso/tick got %h/%b/%b/%b want %h/%b/%b/%b",
                             got.rgb, got.hso, got.vso, got.tick, e.rgb, e.hso, e.vso, e.tick);
                end
            end
        end
    end

    task automatic test_reset();
        step(5, 5, 1'b1, 1'b0, 1'b1, 1'b1);
        step(5, 5, 1'b1, 1'b0, 1'b1, 1'b1);
        vectors++;
        if (dut.boxX_q !== 10'd0 || dut.boxY_q !== 10'd0 || dut.dirX_q !== 1'b1 || dut.dirY_q !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_pos got x=%0d y=%0d dx=%b dy=%b want 0 0 1 1",
                     dut.boxX_q, dut.boxY_q, dut.dirX_q, dut.dirY_q);
        end
    endtask

    task automatic test_colour();
        logic [11:0] got;
`ifdef BOX_BORDER_EN
        localparam logic [11:0] C00 = 12'hFFF;
        localparam logic [11:0] C3110 = 12'hFFF;
`else
        localparam logic [11:0] C00 = 12'hFF0;
        localparam logic [11:0] C3110 = 12'hFF0;
`endif
        step(0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        got = {vif.red, vif.green, vif.blue};
        vectors++;
        if (got !== C00) begin miscompares++; $display("FAIL colour_0_0 got %h want %h", got, C00); end
        step(32, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        got = {vif.red, vif.green, vif.blue};
        vectors++;
        if (got !== 12'h00F) begin miscompares++; $display("FAIL colour_32_0 got %h want 00f", got); end
        step(32, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        got = {vif.red, vif.green, vif.blue};
        vectors++;
        if (got !== 12'h000) begin miscompares++; $display("FAIL colour_blank got %h want 000", got); end
        step(5, 5, 1'b1, 1'b0, 1'b1, 1'b0);
        got = {vif.red, vif.green, vif.blue};
        vectors++;
        if (got !== 12'hFF0) begin miscompares++; $display("FAIL colour_5_5 got %h want ff0", got); end
        step(31, 10, 1'b1, 1'b1, 1'b1, 1'b0);
        got = {vif.red, vif.green, vif.blue};
        vectors++;
        if (got !== C3110) begin miscompares++; $display("FAIL colour_31_10 got %h want %h", got, C3110); end
        step(10, 32, 1'b1, 1'b0, 1'b0, 1'b0);
        step(31, 31, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_single_update();
        step(0, V_RES, 1'b0, 1'b1, 1'b1, 1'b0);
        step(100, 100, 1'b1, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (dut.boxX_q !== 10'd2 || dut.boxY_q !== 10'd0 || vif.frameTick !== 1'b0) begin
            miscompares++;
            $display("FAIL update_x got x=%0d y=%0d tick=%b want 2 0 0", dut.boxX_q, dut.boxY_q, vif.frameTick);
        end
        step(2, 2, 1'b1, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (dut.boxY_q !== 10'd2 || vif.frameTick !== 1'b1) begin
            miscompares++;
            $display("FAIL update_y got y=%0d tick=%b want 2 1", dut.boxY_q, vif.frameTick);
        end
        step(1, 2, 1'b1, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (vif.frameTick !== 1'b0) begin
            miscompares++;
            $display("FAIL tick_width got %b want 0", vif.frameTick);
        end
    endtask

    task automatic test_back_to_back();
        repeat (3) step(0, V_RES, 1'b0, 1'b1, 1'b0, 1'b0);
        probe();
        vectors++;
        if (dut.boxX_q !== 10'd4 || dut.boxY_q !== 10'd4) begin
            miscompares++;
            $display("FAIL ignored_events got x=%0d y=%0d want 4 4", dut.boxX_q, dut.boxY_q);
        end
    endtask

    task automatic test_reset_mid_update();
        step(0, V_RES, 1'b0, 1'b1, 1'b0, 1'b0);
        step(7, 7, 1'b1, 1'b1, 1'b0, 1'b0);
        step(7, 7, 1'b1, 1'b0, 1'b1, 1'b1);
        vectors++;
        if (dut.boxX_q !== 10'd0 || dut.boxY_q !== 10'd0 || vif.frameTick !== 1'b0 || vif.hSyncOut !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_update got x=%0d y=%0d tick=%b hso=%b want 0 0 0 1",
                     dut.boxX_q, dut.boxY_q, vif.frameTick, vif.hSyncOut);
        end
        step(7, 7, 1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (vif.frameTick !== 1'b0) begin
            miscompares++;
            $display("FAIL tick_after_reset got %b want 0", vif.frameTick);
        end
    endtask

    task automatic test_bounce();
        step(0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (224) frame_update();
        vectors++;
        if (dut.boxY_q !== 10'd448 || dut.dirY_q !== 1'b1) begin
            miscompares++;
            $display("FAIL y_at_448 got y=%0d dy=%b want 448 1", dut.boxY_q, dut.dirY_q);
        end
        frame_update();
        vectors++;
        if (dut.boxY_q !== 10'd448 || dut.dirY_q !== 1'b0) begin
            miscompares++;
            $display("FAIL y_bounce got y=%0d dy=%b want 448 0", dut.boxY_q, dut.dirY_q);
        end
        repeat (79) frame_update();
        vectors++;
        if (dut.boxX_q !== 10'd608 || dut.dirX_q !== 1'b1) begin
            miscompares++;
            $display("FAIL x_at_608 got x=%0d dx=%b want 608 1", dut.boxX_q, dut.dirX_q);
        end
        frame_update();
        vectors++;
        if (dut.boxX_q !== 10'd608 || dut.dirX_q !== 1'b0) begin
            miscompares++;
            $display("FAIL x_bounce got x=%0d dx=%b want 608 0", dut.boxX_q, dut.dirX_q);
        end
        frame_update();
        vectors++;
        if (dut.boxX_q !== 10'd606) begin
            miscompares++;
            $display("FAIL x_return got x=%0d want 606", dut.boxX_q);
        end
        step(606, 290, 1'b1, 1'b1, 1'b0, 1'b0);
        step(605, 290, 1'b1, 1'b1, 1'b0, 1'b0);
        step(637, 290, 1'b1, 1'b1, 1'b0, 1'b0);
        step(638, 290, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        vif.hPixel  = '0;
        vif.vLine   = '0;
        vif.vActive = 1'b0;
        vif.hSync   = 1'b1;
        vif.vSync   = 1'b0;
        model_reset();
        @(negedge clock);
        test_reset();
        test_colour();
        test_single_update();
        test_back_to_back();
        test_reset_mid_update();
        test_bounce();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
